// File: rtl/pll_supervisor_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
// Holds the state enum, the default timing constants and the counter width helper.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } sup_state_e;

  localparam int DEF_RESET_CYCLES = 64;
  localparam int DEF_LOCK_TIMEOUT = 100000;
  localparam int DEF_LOCK_STABLE  = 1024;
  localparam int DEF_MAX_RETRIES  = 7;

  // The counter only ever holds 0..limit-1, so clog2 of the largest limit suffices.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Power-up and recovery sequencer for a PLL: reset pulse, lock wait, stability check, release.
// Optional macro PLL_SUPERVISOR_PWD_EN powers the PLL down while latched in FAULT.
module pll_lock_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       soft_reset_req,
  output logic       pll_reset,
  output logic       pll_pwd,
  output logic       sys_reset,
  output logic       locked,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] loss_count
);

  localparam int CW = cnt_width(RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

  sup_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_d;
  logic [7:0]    loss_d;
  logic          lock_s;
  logic          pll_reset_d, sys_reset_d, locked_d, fault_d;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_count;
    loss_d  = loss_count;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RESET_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_LOCK: begin
        // Lock is checked before the timeout so a lock arriving on the last cycle still counts.
        if (lock_s) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_count + 4'd1;
          cnt_d   = '0;
          state_d = (retry_d == RETRY_MAX) ? FAULT : RESET_PLL;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = 4'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = RESET_PLL;
          cnt_d   = '0;
          loss_d  = (loss_count == 8'hFF) ? loss_count : loss_count + 8'd1;
        end
      end
      FAULT: begin
        cnt_d = '0;
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase
    if (soft_reset_req) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      retry_d = 4'd0;
      loss_d  = loss_count;
    end
    pll_reset_d = (state_d == RESET_PLL) || (state_d == FAULT);
    sys_reset_d = (state_d != RUN);
    locked_d    = (state_d == RUN);
    fault_d     = (state_d == FAULT);
  end

  // Outputs are registered from the next-state decode so they move with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_count <= 4'd0;
      loss_count  <= 8'd0;
      pll_reset   <= 1'b1;
      sys_reset   <= 1'b1;
      locked      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_count <= retry_d;
      loss_count  <= loss_d;
      pll_reset   <= pll_reset_d;
      sys_reset   <= sys_reset_d;
      locked      <= locked_d;
      fault       <= fault_d;
    end
  end

`ifdef PLL_SUPERVISOR_PWD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pll_pwd <= 1'b0;
    else       pll_pwd <= (state_d == FAULT);
  end
`else
  assign pll_pwd = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor with short timing parameters.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       soft_reset_req;
  logic       pll_reset;
  logic       pll_pwd;
  logic       sys_reset;
  logic       locked;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] loss_count;

  int tests_run;
  int tests_failed;

`ifdef PLL_SUPERVISOR_PWD_EN
  localparam logic PWD_IN_FAULT = 1'b1;
`else
  localparam logic PWD_IN_FAULT = 1'b0;
`endif

  pll_lock_supervisor #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (20),
    .LOCK_STABLE  (8),
    .MAX_RETRIES  (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pll_lock       (pll_lock),
    .soft_reset_req (soft_reset_req),
    .pll_reset      (pll_reset),
    .pll_pwd        (pll_pwd),
    .sys_reset      (sys_reset),
    .locked         (locked),
    .fault          (fault),
    .retry_count    (retry_count),
    .loss_count     (loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at a negedge with reset just released: this sample is cycle 0.
  task automatic do_reset();
    reset = 1'b1;
    soft_reset_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pll_lock = 1'b0;
    soft_reset_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (pll_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_pll_reset got=%b exp=1", pll_reset); end
    tests_run++; if (sys_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_sys_reset got=%b exp=1", sys_reset); end
    tests_run++; if (pll_pwd !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_pll_pwd got=%b exp=0", pll_pwd); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_locked got=%b exp=0", locked); end
    tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_fault got=%b exp=0", fault); end
    tests_run++; if (retry_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL rst_retry got=%0d exp=0", retry_count); end
    tests_run++; if (loss_count !== 8'd0) begin tests_failed++; $display("[TB] FAIL rst_loss got=%0d exp=0", loss_count); end
  endtask

  task automatic test_normal_lock();
    pll_lock = 1'b0;
    do_reset();
    for (int cyc = 0; cyc <= 21; cyc++) begin
      if (cyc <= 3) begin
        tests_run++; if (pll_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL t1_pll_reset_hi cyc=%0d got=%b exp=1", cyc, pll_reset); end
      end
      if (cyc == 4) begin
        tests_run++; if (pll_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL t1_pll_reset_lo got=%b exp=0", pll_reset); end
      end
      if (cyc == 20) begin
        tests_run++; if (sys_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL t1_sys_reset_c20 got=%b exp=1", sys_reset); end
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL t1_locked_c20 got=%b exp=0", locked); end
      end
      if (cyc == 21) begin
        tests_run++; if (sys_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL t1_sys_reset_c21 got=%b exp=0", sys_reset); end
        tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL t1_locked_c21 got=%b exp=1", locked); end
        tests_run++; if (retry_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL t1_retry got=%0d exp=0", retry_count); end
      end
      if (cyc == 10) pll_lock = 1'b1;
      if (cyc < 21) step();
    end
  endtask

  task automatic test_timeout_fault();
    pll_lock = 1'b0;
    do_reset();
    for (int cyc = 0; cyc <= 80; cyc++) begin
      if (cyc == 23) begin
        tests_run++; if (pll_reset !== 1'b0 || retry_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL t2_c23 got pll_reset=%b retry=%0d exp 0/0", pll_reset, retry_count); end
      end
      if (cyc == 24) begin
        tests_run++; if (pll_reset !== 1'b1 || retry_count !== 4'd1) begin tests_failed++; $display("[TB] FAIL t2_c24 got pll_reset=%b retry=%0d exp 1/1", pll_reset, retry_count); end
      end
      if (cyc == 48) begin
        tests_run++; if (retry_count !== 4'd2 || fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL t2_c48 got retry=%0d fault=%b exp 2/0", retry_count, fault); end
      end
      if (cyc == 71) begin
        tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL t2_c71_fault got=%b exp=0", fault); end
      end
      if (cyc == 72 || cyc == 80) begin
        tests_run++; if (fault !== 1'b1) begin tests_failed++; $display("[TB] FAIL t2_fault cyc=%0d got=%b exp=1", cyc, fault); end
        tests_run++; if (pll_reset !== 1'b1 || sys_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL t2_resets cyc=%0d got pll_reset=%b sys_reset=%b exp 1/1", cyc, pll_reset, sys_reset); end
        tests_run++; if (retry_count !== 4'd3) begin tests_failed++; $display("[TB] FAIL t2_retry cyc=%0d got=%0d exp=3", cyc, retry_count); end
        tests_run++; if (pll_pwd !== PWD_IN_FAULT) begin tests_failed++; $display("[TB] FAIL t2_pwd cyc=%0d got=%b exp=%b", cyc, pll_pwd, PWD_IN_FAULT); end
      end
      if (cyc < 80) step();
    end
  endtask

  task automatic test_soft_reset();
    int k;
    soft_reset_req = 1'b1;
    step();
    soft_reset_req = 1'b0;
    tests_run++; if (pll_reset !== 1'b1 || fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL t3_state got pll_reset=%b fault=%b exp 1/0", pll_reset, fault); end
    tests_run++; if (retry_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL t3_retry got=%0d exp=0", retry_count); end
    tests_run++; if (pll_pwd !== 1'b0) begin tests_failed++; $display("[TB] FAIL t3_pwd got=%b exp=0", pll_pwd); end
    pll_lock = 1'b1;
    for (k = 0; k < 60 && locked !== 1'b1; k++) step();
    tests_run++; if (locked !== 1'b1 || sys_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL t3_run got locked=%b sys_reset=%b exp 1/0", locked, sys_reset); end
  endtask

  task automatic test_lock_loss();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      if (cyc == 2) begin
        tests_run++; if (sys_reset !== 1'b0 || locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL t4_c2 got sys_reset=%b locked=%b exp 0/1", sys_reset, locked); end
      end
      if (cyc == 3) begin
        tests_run++; if (sys_reset !== 1'b1 || locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL t4_c3 got sys_reset=%b locked=%b exp 1/0", sys_reset, locked); end
        tests_run++; if (loss_count !== 8'd1) begin tests_failed++; $display("[TB] FAIL t4_loss got=%0d exp=1", loss_count); end
      end
      if (cyc >= 3 && cyc <= 6) begin
        tests_run++; if (pll_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL t4_pll_reset_hi cyc=%0d got=%b exp=1", cyc, pll_reset); end
      end
      if (cyc == 7) begin
        tests_run++; if (pll_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL t4_pll_reset_lo got=%b exp=0", pll_reset); end
      end
      if (cyc == 15) begin
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL t4_locked_c15 got=%b exp=0", locked); end
      end
      if (cyc == 16) begin
        tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL t4_locked_c16 got=%b exp=1", locked); end
      end
      if (cyc < 16) step();
    end
  endtask

  task automatic test_stabilize_glitch();
    pll_lock = 1'b1;
    do_reset();
    for (int cyc = 0; cyc <= 20; cyc++) begin
      if (cyc == 11) begin
        tests_run++; if (sys_reset !== 1'b1 || retry_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL t5_c11 got sys_reset=%b retry=%0d exp 1/0", sys_reset, retry_count); end
      end
      if (cyc == 13 || cyc == 19) begin
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL t5_early_run cyc=%0d got locked=%b exp=0", cyc, locked); end
      end
      if (cyc == 20) begin
        tests_run++; if (locked !== 1'b1 || sys_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL t5_run got locked=%b sys_reset=%b exp 1/0", locked, sys_reset); end
        tests_run++; if (retry_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL t5_retry got=%0d exp=0", retry_count); end
      end
      if (cyc == 8) pll_lock = 1'b0;
      if (cyc == 9) pll_lock = 1'b1;
      if (cyc < 20) step();
    end
  endtask

  task automatic test_loss_saturation();
    int k;
    bit stuck;
    stuck = 1'b0;
    for (int i = 1; i <= 256 && !stuck; i++) begin
      pll_lock = 1'b0;
      step();
      pll_lock = 1'b1;
      for (k = 0; k < 6 && locked !== 1'b0; k++) step();
      for (k = 0; k < 40 && locked !== 1'b1; k++) step();
      if (locked !== 1'b1) begin
        stuck = 1'b1;
        tests_run++; tests_failed++;
        $display("[TB] FAIL t6_relock iter=%0d got locked=%b exp=1", i, locked);
      end
      if (i == 1 || i == 2) begin
        tests_run++; if (loss_count !== 8'(i)) begin tests_failed++; $display("[TB] FAIL t6_loss iter=%0d got=%0d exp=%0d", i, loss_count, i); end
      end
      if (i == 255 || i == 256) begin
        tests_run++; if (loss_count !== 8'd255) begin tests_failed++; $display("[TB] FAIL t6_sat iter=%0d got=%0d exp=255", i, loss_count); end
      end
    end
  endtask

  task automatic test_async_reset();
    pll_lock = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) step();
    tests_run++; if (pll_reset !== 1'b0 || sys_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL t6_wait_lock got pll_reset=%b sys_reset=%b exp 0/1", pll_reset, sys_reset); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++; if (pll_reset !== 1'b1 || sys_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL t6_async_resets got pll_reset=%b sys_reset=%b exp 1/1", pll_reset, sys_reset); end
    tests_run++; if (locked !== 1'b0 || fault !== 1'b0 || pll_pwd !== 1'b0) begin tests_failed++; $display("[TB] FAIL t6_async_flags got locked=%b fault=%b pwd=%b exp 0/0/0", locked, fault, pll_pwd); end
    tests_run++; if (retry_count !== 4'd0 || loss_count !== 8'd0) begin tests_failed++; $display("[TB] FAIL t6_async_counts got retry=%0d loss=%0d exp 0/0", retry_count, loss_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    pll_lock = 1'b0;
    soft_reset_req = 1'b0;
    test_reset();
    test_normal_lock();
    test_timeout_fault();
    test_soft_reset();
    test_lock_loss();
    test_stabilize_glitch();
    test_loss_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
